// File: rtl/vio_cmd_decode.sv
// vio_cmd_decode: receive end of the VIO async-output path.
//   Synchronizes the 16-bit VIO word and waits for the toggle strobe to flip and
//   the word to settle. Each accepted word then runs exactly one command, and the
//   status is returned to the ILA trigger input.
// Ports:
//   CLK          design clock, rising edge
//   RESET_N      asynchronous active-low reset
//   VIO_ASYNC_IN [15]=toggle strobe, [14:12]=opcode, [11:0]=data (asynchronous)
//   PROBE_SEL    probe-mux select (opcode 1)
//   USER_CTRL    general control register (opcode 2)
//   PULSE_OUT    timed pulse, high for data cycles (opcode 3)
//   CMD_CNT      accepted-command count, cleared by opcode 4
//   CMD_ACCEPT   one-cycle strobe per executed command
//   TRIG_OUT     {CMD_ACCEPT, last opcode, last data, PULSE_OUT}
module vio_cmd_decode #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] VIO_ASYNC_IN,
    output logic [3:0]  PROBE_SEL,
    output logic [11:0] USER_CTRL,
    output logic        PULSE_OUT,
    output logic [7:0]  CMD_CNT,
    output logic        CMD_ACCEPT,
    output logic [16:0] TRIG_OUT
);
    // One counter serves both the INIT wait and the SETTLE window.
    localparam int CNT_MAX = (SETTLE_CYCLES > SYNC_STAGES + 1) ? SETTLE_CYCLES : SYNC_STAGES + 1;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INIT_LAST   = CW'(SYNC_STAGES);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SETTLE, ST_EXEC} state_t;

    logic [15:0]   r_sync [SYNC_STAGES];
    logic [15:0]   w_s;
    state_t        r_state;
    logic          r_tog_ref;
    logic [15:0]   r_hold;
    logic [CW-1:0] r_cnt;
    logic [11:0]   r_pulse_cnt;
    logic          r_pulse;
    logic          r_accept;
    logic [3:0]    r_probe_sel;
    logic [11:0]   r_user_ctrl;
    logic [7:0]    r_cmd_cnt;
    logic [2:0]    r_last_op;
    logic [11:0]   r_last_data;
    logic [2:0]    w_op;
    logic [11:0]   w_data;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= VIO_ASYNC_IN;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_op   = r_hold[14:12];
    assign w_data = r_hold[11:0];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_INIT;
            r_tog_ref   <= 1'b0;
            r_hold      <= '0;
            r_cnt       <= '0;
            r_pulse_cnt <= '0;
            r_pulse     <= 1'b0;
            r_accept    <= 1'b0;
            r_probe_sel <= '0;
            r_user_ctrl <= '0;
            r_cmd_cnt   <= '0;
            r_last_op   <= '0;
            r_last_data <= '0;
        end else begin
            r_accept    <= 1'b0;
            // r_pulse_cnt holds the high cycles still owed, including the current one.
            r_pulse_cnt <= (r_pulse_cnt != 12'd0) ? r_pulse_cnt - 12'd1 : 12'd0;
            r_pulse     <= r_pulse_cnt > 12'd1;
            case (r_state)
                ST_INIT: begin
                    // Adopt whatever toggle level is present so the reset level never fires.
                    if (r_cnt == INIT_LAST) begin
                        r_tog_ref <= w_s[15];
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_s[15] != r_tog_ref) begin
                        r_hold  <= w_s;
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_s != r_hold) begin
                        r_hold <= w_s;
                        r_cnt  <= '0;
                    end else if (r_cnt == SETTLE_LAST) begin
                        // A toggle that returned to its reference level is dropped.
                        r_state <= (r_hold[15] != r_tog_ref) ? ST_EXEC : ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_accept    <= 1'b1;
                    r_tog_ref   <= r_hold[15];
                    r_last_op   <= w_op;
                    r_last_data <= w_data;
                    r_cmd_cnt   <= (w_op == 3'd4) ? 8'd0 : r_cmd_cnt + 8'd1;
                    if (w_op == 3'd1) r_probe_sel <= w_data[3:0];
                    if (w_op == 3'd2) r_user_ctrl <= w_data;
                    if (w_op == 3'd3) begin
                        r_pulse_cnt <= w_data;
                        r_pulse     <= w_data != 12'd0;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign PROBE_SEL  = r_probe_sel;
    assign USER_CTRL  = r_user_ctrl;
    assign PULSE_OUT  = r_pulse;
    assign CMD_CNT    = r_cmd_cnt;
    assign CMD_ACCEPT = r_accept;
    assign TRIG_OUT   = {r_accept, r_last_op, r_last_data, r_pulse};
endmodule
